weight_fetch_sequencer: RTL and testbench
=========================================

Name: weight_fetch_sequencer

Overview:
- Read-side master for one weight BRAM (16-bit words, negedge-registered read port, EN/WE control).
- On START it reads addresses 0..DEPTH-1 in order and streams the words to the neuron MAC datapath over a valid/ready interface.
- It absorbs the BRAM's read latency and downstream backpressure with a 2-entry output buffer.
- It sits between a Weight_x_y_BRAM instance and the MAC of the same neuron.

Parameters:
- DEPTH, 28, number of words streamed per START (addresses 0..DEPTH-1).
- ADDR_W, 5, BRAM address width; must satisfy 2^ADDR_W >= DEPTH.
- DATA_W, 16, weight word width.

Ports:
- CLK  in  1  system clock; all sequencer flops on posedge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  level-sampled start request; honoured only in IDLE.
- ABORT  in  1  synchronous cancel of the current pass.
- BUSY  out  1  high in FETCH and DRAIN.
- DONE  out  1  one-cycle pulse when the last word has been accepted.
- BRAM_ADDR  out  ADDR_W  BRAM address, registered.
- BRAM_EN  out  1  BRAM enable, registered; high only on read-issue cycles.
- BRAM_WE  out  1  constant 0.
- BRAM_DI  out  DATA_W  constant 0.
- BRAM_DO  in  DATA_W  BRAM read data.
- W_DATA  out  DATA_W  head word of the output buffer.
- W_VALID  out  1  buffer non-empty.
- W_LAST  out  1  high with the word read from address DEPTH-1.
- W_READY  in  1  downstream accept.

Behaviour:
- Reset (async, RST=1): state IDLE; BUSY=0, DONE=0, BRAM_EN=0, BRAM_ADDR=0, W_VALID=0, W_LAST=0, W_DATA=0; buffer empty; issue counter 0; no read outstanding.
- BRAM timing: BRAM_EN/BRAM_ADDR change at posedge t. The BRAM samples them at the following negedge, and BRAM_DO is pushed into the buffer at posedge t+1. Exactly one read is outstanding per cycle at most.
- Transfer rule: a word transfers when W_VALID && W_READY at a posedge. W_DATA/W_LAST must stay stable while W_VALID=1 and W_READY=0.
- Issue rule (at each posedge, state FETCH): BRAM_EN<=1 and BRAM_ADDR<=issue counter, then the counter increments, only if (occupancy after this edge's push/pop) + (read being issued) <= 2. Otherwise BRAM_EN<=0 and BRAM_ADDR holds.
- Buffer never overflows. A push from BRAM_DO and a pop in the same edge are both honoured.
- Throughput: with W_READY held high, one word per cycle, no bubbles after the first.
- FSM:
  - IDLE: START=1 -> FETCH; counter<=0; first read issued on the same edge (BRAM_EN=1, ADDR=0).
  - FETCH: after the read of DEPTH-1 is issued -> DRAIN.
  - DRAIN: BRAM_EN=0. When the buffer is empty and no read is outstanding (i.e. last word accepted) -> IDLE, with DONE=1 for exactly that one cycle.
- Latency: START sampled at edge t0 -> W_VALID=1 after edge t0+1. Pass time with READY=1 is DEPTH+1 cycles to the last transfer; DONE is asserted from the edge where the last word transfers.
- W_LAST is tagged at issue time (address == DEPTH-1) and travels with the word through the buffer.
- START while BUSY: ignored, no restart. START on the same edge that DONE asserts is also ignored; a new pass starts on the next edge START is high in IDLE.
- ABORT in FETCH/DRAIN:
  - Next edge goes to IDLE, buffer flushed, W_VALID=0, any outstanding read data discarded, no DONE.
  - ABORT has priority over a simultaneous transfer.
  - ABORT in IDLE has no effect.
- RST asserted mid-pass: immediate return to reset values. The BRAM contents are unaffected, since WE is never driven.
- Address wrap: none; the counter stops at DEPTH-1. Values above DEPTH-1 are never driven.

Optional Feature:
- Macro: WFETCH_CHECKSUM_EN.
- Defined:
  - Adds output port CHECKSUM (DATA_W), a modulo-2^DATA_W running sum of W_DATA over accepted transfers in the current pass.
  - Cleared to 0 on RST and on the IDLE->FETCH edge; not cleared by ABORT.
  - Final value is stable from the DONE cycle until the next START is accepted.
- Undefined: no CHECKSUM port and no adder logic; all other behaviour identical.

Test Plan:
- Preload BRAM word[i]=i+1 (DEPTH=28), W_READY=1, pulse START -> 28 transfers of 1..28 on consecutive cycles; W_LAST only with 28; DONE once, on the cycle after the 28th transfer edge; BUSY low afterwards.
- Same preload, W_READY toggling 1,0,0,1 repeatedly -> all 28 words in order, none duplicated or dropped; BRAM_EN never issues when 2 words are held plus 1 outstanding; W_DATA stable while stalled.
- Same preload, W_READY=0 for 10 cycles after START -> exactly 2 BRAM reads issued (addr 0,1); W_DATA=1 held; after READY=1 the stream resumes at 2 with no gap beyond refill.
- START re-pulsed at transfer 5, then ABORT at transfer 12 -> no restart at 5; after ABORT, W_VALID=0 next cycle, no DONE, BUSY=0; a following START streams from word 1.
- RST asserted asynchronously mid-cycle during transfer 7 -> all outputs at reset values before the next posedge; next START yields a full clean pass.
- With WFETCH_CHECKSUM_EN and word[i]=0x1000 for all i -> CHECKSUM=0xC000 (28*0x1000 mod 2^16) at DONE.

Source files
------------

// File: rtl/weight_fetch_sequencer_if.sv
// rtl/weight_fetch_sequencer_if.sv - BRAM read port and weight stream bundle for weight_fetch_sequencer
interface weight_fetch_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] BRAM_ADDR;
    logic              BRAM_EN;
    logic              BRAM_WE;
    logic [DATA_W-1:0] BRAM_DI;
    logic [DATA_W-1:0] BRAM_DO;
    logic [DATA_W-1:0] W_DATA;
    logic              W_VALID;
    logic              W_LAST;
    logic              W_READY;

    modport master (
        output BRAM_ADDR, BRAM_EN, BRAM_WE, BRAM_DI,
        input  BRAM_DO,
        output W_DATA, W_VALID, W_LAST,
        input  W_READY
    );

    modport slave (
        input  BRAM_ADDR, BRAM_EN, BRAM_WE, BRAM_DI,
        output BRAM_DO,
        input  W_DATA, W_VALID, W_LAST,
        output W_READY
    );
endinterface

// File: rtl/weight_fetch_sequencer.sv
// rtl/weight_fetch_sequencer.sv - streams weight BRAM words 0..DEPTH-1 through a 2-entry buffer
// Optional running checksum output enabled by WFETCH_CHECKSUM_EN.
module weight_fetch_sequencer #(
    parameter int DEPTH  = 28,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic START,
    input  logic ABORT,
    output logic BUSY,
    output logic DONE,
`ifdef WFETCH_CHECKSUM_EN
    output logic [DATA_W-1:0] CHECKSUM,
`endif
    weight_fetch_sequencer_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] cnt, addr_q;
    logic              en_q, pend_last, done_q, done_nxt;
    logic [DATA_W-1:0] d0, d1, d0_nxt, d1_nxt;
    logic              l0, l1, l0_nxt, l1_nxt;
    logic [1:0]        occ, occ_mid;
    logic              push, pop, issue, start_pass, kill;

    // Occupancy after this edge's push/pop decides whether one more read may be in flight.
    always_comb begin
        push       = en_q;
        pop        = (occ != 2'd0) && bus.W_READY;
        occ_mid    = occ + {1'b0, push} - {1'b0, pop};
        start_pass = (state == IDLE) && START;
        kill       = ABORT && (state != IDLE);
        issue      = start_pass || ((state == FETCH) && !ABORT && (occ_mid <= 2'd1));
    end

    // Shift toward the head on pop; the returning word lands in the first free slot.
    always_comb begin
        d0_nxt = d0;
        d1_nxt = d1;
        l0_nxt = l0;
        l1_nxt = l1;
        if (pop) begin
            d0_nxt = d1;
            l0_nxt = l1;
        end
        if (push) begin
            if (occ_mid == 2'd1) begin
                d0_nxt = bus.BRAM_DO;
                l0_nxt = pend_last;
            end else begin
                d1_nxt = bus.BRAM_DO;
                l1_nxt = pend_last;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE:  if (START) state_nxt = (DEPTH == 1) ? DRAIN : FETCH;
            FETCH: begin
                if (ABORT)                           state_nxt = IDLE;
                else if (issue && cnt == LAST_ADDR)  state_nxt = DRAIN;
            end
            DRAIN: begin
                if (ABORT) state_nxt = IDLE;
                else if (occ_mid == 2'd0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY          = (state != IDLE);
        DONE          = done_q;
        bus.BRAM_ADDR = addr_q;
        bus.BRAM_EN   = en_q;
        bus.BRAM_WE   = 1'b0;
        bus.BRAM_DI   = '0;
        bus.W_DATA    = d0;
        bus.W_VALID   = (occ != 2'd0);
        bus.W_LAST    = l0 && (occ != 2'd0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt       <= '0;
            addr_q    <= '0;
            en_q      <= 1'b0;
            pend_last <= 1'b0;
            done_q    <= 1'b0;
            occ       <= 2'd0;
            d0        <= '0;
            d1        <= '0;
            l0        <= 1'b0;
            l1        <= 1'b0;
        end else begin
            done_q <= done_nxt;
            if (kill) begin
                occ       <= 2'd0;
                en_q      <= 1'b0;
                pend_last <= 1'b0;
            end else begin
                occ  <= occ_mid;
                d0   <= d0_nxt;
                d1   <= d1_nxt;
                l0   <= l0_nxt;
                l1   <= l1_nxt;
                en_q <= issue;
                if (start_pass) begin
                    addr_q    <= '0;
                    pend_last <= (DEPTH == 1);
                    cnt       <= ADDR_W'((DEPTH > 1) ? 1 : 0);
                end else if (issue) begin
                    addr_q    <= cnt;
                    pend_last <= (cnt == LAST_ADDR);
                    if (cnt != LAST_ADDR) cnt <= cnt + ADDR_W'(1);
                end
            end
        end
    end

`ifdef WFETCH_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)               csum <= '0;
        else if (start_pass)   csum <= '0;
        else if (pop && !kill) csum <= csum + d0;
    end

    assign CHECKSUM = csum;
`endif
endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// tb/tb_weight_fetch_sequencer.sv - randomized scoreboard bench for weight_fetch_sequencer
module tb_weight_fetch_sequencer;
    localparam int DEPTH = 28;

    logic clk, rst, start, abort, busy, done;
`ifdef WFETCH_CHECKSUM_EN
    logic [15:0] checksum;
`endif
    weight_fetch_sequencer_if #(.ADDR_W(5), .DATA_W(16)) bif ();

    weight_fetch_sequencer #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(16)) dut (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort),
        .BUSY(busy), .DONE(done),
`ifdef WFETCH_CHECKSUM_EN
        .CHECKSUM(checksum),
`endif
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:31];
    always @(negedge clk) if (bif.BRAM_EN) bif.BRAM_DO <= mem[bif.BRAM_ADDR];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, issued, xfers, max_inflight, stall_bad, addr_bad, done_cnt, done_cyc;
    int first_xfer_cyc, last_xfer_cyc, start_cyc;
    logic s_valid, s_last, s_en, s_busy, s_done, s_we;
    logic [15:0] s_data, s_di, prev_data;
    logic [4:0] s_addr;
    logic prev_x, prev_stall, prev_last;
    logic [15:0] got_q[$];
    logic got_last_q[$];

    task automatic reset_model();
        issued = 0; xfers = 0; max_inflight = 0; stall_bad = 0; addr_bad = 0;
        done_cnt = 0; done_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
        prev_x = 0; prev_stall = 0; prev_data = 0; prev_last = 0;
        got_q.delete(); got_last_q.delete();
    endtask

    // One clock: sample outputs, update reference bookkeeping, then drive inputs for the next edge.
    task automatic cycle(input logic rdy, input logic abt, input logic st);
        @(negedge clk);
        cyc++;
        if (prev_x) xfers++;
        s_valid = bif.W_VALID; s_last = bif.W_LAST; s_data = bif.W_DATA;
        s_en = bif.BRAM_EN; s_addr = bif.BRAM_ADDR; s_we = bif.BRAM_WE; s_di = bif.BRAM_DI;
        s_busy = busy; s_done = done;
        if (s_en) begin
            if (int'(s_addr) != issued) addr_bad++;
            issued++;
        end
        if (issued - xfers > max_inflight) max_inflight = issued - xfers;
        if (prev_stall && s_valid && (s_data !== prev_data || s_last !== prev_last)) stall_bad++;
        if (s_done) begin done_cnt++; done_cyc = cyc; end
        bif.W_READY = rdy; abort = abt; start = st;
        if (st) start_cyc = cyc;
        prev_x = s_valid && rdy && !abt;
        prev_stall = s_valid && !rdy && !abt;
        prev_data = s_data; prev_last = s_last;
        if (prev_x) begin
            got_q.push_back(s_data);
            got_last_q.push_back(s_last);
            if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
        end
    endtask

    task automatic run_pass(input int mode, input int budget);
        logic r;
        for (int k = 0; k < budget && done_cnt == 0; k++) begin
            case (mode)
                0: r = 1'b1;
                1: r = (k % 4 == 0) || (k % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            cycle(r, 1'b0, 1'b0);
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 32; i++) mem[i] = 16'(i + 1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    endtask

    // Whole-pass scoreboard: words must be mem[0..DEPTH-1] in order, LAST only on the final one.
    task automatic check_pass(input string tag);
        int bad = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            if (i < DEPTH && got_q[i] !== mem[i]) bad++;
            if (got_last_q[i] !== (i == DEPTH - 1)) bad++;
        end
        n_checks++;
        if (got_q.size() != DEPTH || bad != 0) begin
            n_fail++;
            $display("FAIL %s stream: got %0d words (%0d bad), want %0d in order", tag, got_q.size(), bad, DEPTH);
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != last_xfer_cyc + 1) begin
            n_fail++;
            $display("FAIL %s done: count %0d at cyc %0d, want 1 at cyc %0d", tag, done_cnt, done_cyc, last_xfer_cyc + 1);
        end
        n_checks++;
        if (max_inflight > 2 || stall_bad != 0 || addr_bad != 0) begin
            n_fail++;
            $display("FAIL %s flow: inflight %0d stall_err %0d addr_err %0d, want <=2/0/0", tag, max_inflight, stall_bad, addr_bad);
        end
        n_checks++;
        if (s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_end: got %b want 0", tag, s_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; abort = 0; bif.W_READY = 0; bif.BRAM_DO = 0;
        reset_model();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, bif.BRAM_EN, bif.W_VALID, bif.W_LAST, bif.BRAM_WE} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000", {busy, done, bif.BRAM_EN, bif.W_VALID, bif.W_LAST, bif.BRAM_WE});
        end
        n_checks++;
        if (bif.BRAM_ADDR !== 5'd0 || bif.W_DATA !== 16'd0 || bif.BRAM_DI !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: addr %0h data %0h di %0h want 0", bif.BRAM_ADDR, bif.W_DATA, bif.BRAM_DI);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        fill_ramp(); reset_model();
        cycle(1, 0, 1);
        run_pass(0, 60);
        repeat (3) cycle(1, 0, 0);
        check_pass("stream");
        n_checks++;
        if (first_xfer_cyc - start_cyc != 2 || last_xfer_cyc - first_xfer_cyc != DEPTH - 1) begin
            n_fail++;
            $display("FAIL stream_timing: first +%0d span %0d, want +2 span %0d", first_xfer_cyc - start_cyc, last_xfer_cyc - first_xfer_cyc, DEPTH - 1);
        end
        n_checks++;
        if (s_we !== 1'b0 || s_di !== 16'd0) begin
            n_fail++;
            $display("FAIL bram_write: we %b di %0h want 0/0", s_we, s_di);
        end
    endtask

    task automatic test_backpressure();
        fill_random(); reset_model();
        cycle(1, 0, 1);
        run_pass(1, 200);
        check_pass("pattern_1001");
    endtask

    task automatic test_stall_start();
        fill_ramp(); reset_model();
        cycle(0, 0, 1);
        repeat (10) cycle(0, 0, 0);
        n_checks++;
        if (issued != 2 || s_valid !== 1'b1 || s_data !== 16'd1) begin
            n_fail++;
            $display("FAIL stall_hold: reads %0d valid %b data %0h, want 2/1/1", issued, s_valid, s_data);
        end
        run_pass(0, 60);
        check_pass("stall_start");
        n_checks++;
        if (last_xfer_cyc - first_xfer_cyc != DEPTH - 1) begin
            n_fail++;
            $display("FAIL stall_resume: span %0d want %0d", last_xfer_cyc - first_xfer_cyc, DEPTH - 1);
        end
    endtask

    task automatic test_random_ready();
        for (int p = 0; p < 3; p++) begin
            fill_random(); reset_model();
            cycle(1'($urandom_range(0, 1)), 0, 1);
            run_pass(2, 300);
            check_pass("random_ready");
        end
    endtask

    task automatic test_back_to_back();
        fill_random(); reset_model();
        cycle(1, 0, 1);
        run_pass(0, 60);
        check_pass("b2b_first");
        reset_model();
        cycle(1, 0, 1);
        run_pass(2, 300);
        check_pass("b2b_second");
    endtask

    task automatic test_restart_abort();
        fill_ramp(); reset_model();
        cycle(1, 0, 1);
        for (int k = 0; k < 60 && got_q.size() < 11; k++) cycle(1, 0, got_q.size() == 4);
        cycle(1, 1, 0);
        cycle(1, 0, 0);
        n_checks++;
        if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: valid %b busy %b want 0/0", s_valid, s_busy);
        end
        repeat (4) cycle(1, 0, 0);
        n_checks++;
        if (got_q.size() != 11 || done_cnt != 0) begin
            n_fail++;
            $display("FAIL abort_count: words %0d done %0d want 11/0", got_q.size(), done_cnt);
        end
        begin
            int bad = 0;
            for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 16'(i + 1)) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL no_restart: %0d out-of-order words, want 0", bad);
            end
        end
        reset_model();
        cycle(1, 0, 1);
        run_pass(0, 60);
        check_pass("after_abort");
    endtask

    task automatic test_async_reset();
        fill_ramp(); reset_model();
        cycle(1, 0, 1);
        for (int k = 0; k < 60 && got_q.size() < 7; k++) cycle(1, 0, 0);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, bif.BRAM_EN, bif.W_VALID, bif.W_LAST} !== 5'b0 || bif.BRAM_ADDR !== 5'd0 || bif.W_DATA !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: flags %b addr %0h data %0h want 0", {busy, done, bif.BRAM_EN, bif.W_VALID, bif.W_LAST}, bif.BRAM_ADDR, bif.W_DATA);
        end
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        cycle(1, 0, 1);
        run_pass(0, 60);
        check_pass("after_reset");
    endtask

`ifdef WFETCH_CHECKSUM_EN
    task automatic test_checksum();
        for (int i = 0; i < 32; i++) mem[i] = 16'h1000;
        reset_model();
        cycle(1, 0, 1);
        run_pass(1, 200);
        n_checks++;
        if (checksum !== 16'hC000) begin
            n_fail++;
            $display("FAIL checksum_done: got %0h want c000", checksum);
        end
        repeat (3) cycle(1, 0, 0);
        n_checks++;
        if (checksum !== 16'hC000) begin
            n_fail++;
            $display("FAIL checksum_hold: got %0h want c000", checksum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_stall_start();
        test_random_ready();
        test_back_to_back();
        test_restart_abort();
        test_async_reset();
`ifdef WFETCH_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
